// File: rtl/control_unit_pkg.sv
// control_unit_pkg
//   Shared constants for the multi-cycle control unit: opcode values, FSM state
//   encoding, bus-mux select codes, ALU operation codes and branch condition codes.
//   Also provides the opcode -> ALU operation mapping used during EX2.
package control_unit_pkg;

    // Opcodes, IR[15:13]
    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVT = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_LD  = 3'd4;
    localparam logic [2:0] OP_ST  = 3'd5;
    localparam logic [2:0] OP_AND = 3'd6;
    localparam logic [2:0] OP_B   = 3'd7;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_F0   = 3'd1;
    localparam logic [2:0] ST_F1   = 3'd2;
    localparam logic [2:0] ST_EX1  = 3'd3;
    localparam logic [2:0] ST_EX2  = 3'd4;
    localparam logic [2:0] ST_EX3  = 3'd5;

    // Bus mux selects; 0..7 select R[i]
    localparam logic [3:0] SEL_IMM = 4'd8;
    localparam logic [3:0] SEL_G   = 4'd9;
    localparam logic [3:0] SEL_DIN = 4'd10;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    // Branch conditions, IR[11:9]
    localparam logic [2:0] COND_AL0 = 3'd0;
    localparam logic [2:0] COND_EQ  = 3'd1;
    localparam logic [2:0] COND_NE  = 3'd2;
    localparam logic [2:0] COND_CC  = 3'd3;
    localparam logic [2:0] COND_CS  = 3'd4;
    localparam logic [2:0] COND_PL  = 3'd5;
    localparam logic [2:0] COND_MI  = 3'd6;
    localparam logic [2:0] COND_AL7 = 3'd7;

    function automatic logic [1:0] alu_for_op(input logic [2:0] op);
        logic [1:0] res;
        res = ALU_ADD;
        if (op == OP_SUB) res = ALU_SUB;
        if (op == OP_AND) res = ALU_AND;
        return res;
    endfunction

endpackage

// File: rtl/cu_cond_eval.sv
// cu_cond_eval
//   Combinational branch-condition evaluator.
//   Ports:
//     cond    in  3  condition field IR[11:9]
//     flag_z  in  1  zero flag
//     flag_n  in  1  negative flag
//     flag_c  in  1  carry flag
//     taken   out 1  branch is taken
module cu_cond_eval
    import control_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       flag_c,
    output logic       taken
);

    always_comb begin
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = flag_z;
            COND_NE: taken = ~flag_z;
            COND_CC: taken = ~flag_c;
            COND_CS: taken = flag_c;
            COND_PL: taken = ~flag_n;
            COND_MI: taken = flag_n;
            default: taken = 1'b1;  // COND_AL0 / COND_AL7
        endcase
    end

endmodule

// File: rtl/control_unit_seq.sv
// control_unit_seq
//   Multi-cycle control FSM for the simple processor: fetch through PC
//   (R[NUM_REGS-1]), execute MV/MVT/ADD/SUB/AND/LD/ST/B, memory req/ready
//   handshake with optional wait timeout, continuous run.
//   Optional feature macro: CU_COND_BRANCH_EN (conditional branches using
//   flag_z/flag_n/flag_c); when undefined every B is taken.
//   Ports:
//     clk, reset (sync, active-high), run (level)
//     IR_out      in   instruction register
//     mem_ready   in   memory completes current request
//     flag_z/n/c  in   ALU flags
//     sel         out  bus mux select
//     alu_op      out  ALU operation
//     IR_in, A_in, G_in, ADDR_in, DOUT_in  out  register load enables
//     RX_in       out  one-hot register-file write enable
//     pc_incr, mem_req, W_D, done, err     out  control / status
module control_unit_seq
    import control_unit_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned NUM_REGS     = 8,
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [15:0]         IR_out,
    input  logic                mem_ready,
    input  logic                flag_z,
    input  logic                flag_n,
    input  logic                flag_c,
    output logic [3:0]          sel,
    output logic [1:0]          alu_op,
    output logic                IR_in,
    output logic                A_in,
    output logic                G_in,
    output logic                ADDR_in,
    output logic                DOUT_in,
    output logic [NUM_REGS-1:0] RX_in,
    output logic                pc_incr,
    output logic                mem_req,
    output logic                W_D,
    output logic                done,
    output logic                err
);

    if (NUM_REGS < 2 || NUM_REGS > 8 || DATA_W < 8) begin : g_param_check
        $error("control_unit_seq: unsupported NUM_REGS or DATA_W");
    end

    localparam int unsigned CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [3:0] SEL_PC = 4'(NUM_REGS - 1);

    logic [2:0] state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [2:0] op, rx, ry;
    logic imm;
    logic br_taken;
    logic timeout;
    logic [2:0] retire_state;
    logic [NUM_REGS-1:0] rx_dec, pc_dec;

    assign op  = IR_out[15:13];
    assign imm = IR_out[12];
    assign rx  = IR_out[11:9];
    assign ry  = IR_out[2:0];

    // Offset bits belong to the datapath; flags are only consumed by the evaluator.
    logic unused_bits;
    assign unused_bits = ^{IR_out[8:3], flag_z, flag_n, flag_c};

    // RX indices at or above NUM_REGS decode to no write enable.
    always_comb begin
        rx_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rx_dec[i] = (32'(rx) == i);
        end
    end

    assign pc_dec = {1'b1, {(NUM_REGS - 1){1'b0}}};

`ifdef CU_COND_BRANCH_EN
    cu_cond_eval u_cond_eval (
        .cond   (rx),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_c (flag_c),
        .taken  (br_taken)
    );
`else
    assign br_taken = 1'b1;
`endif

    // Only meaningful while a memory request is outstanding; the counter is
    // cleared outside wait states so each request starts from zero.
    assign timeout = (MEM_WAIT_MAX != 0) && (wait_cnt_q == CNT_W'(MEM_WAIT_MAX));
    assign retire_state = run ? ST_F0 : ST_IDLE;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        sel        = 4'd0;
        alu_op     = ALU_ADD;
        IR_in      = 1'b0;
        A_in       = 1'b0;
        G_in       = 1'b0;
        ADDR_in    = 1'b0;
        DOUT_in    = 1'b0;
        RX_in      = '0;
        pc_incr    = 1'b0;
        mem_req    = 1'b0;
        W_D        = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_F0;
            end

            ST_F0: begin
                sel     = SEL_PC;
                ADDR_in = 1'b1;
                pc_incr = 1'b1;
                state_d = ST_F1;
            end

            ST_F1: begin
                if (timeout) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IR_in   = 1'b1;
                        state_d = ST_EX1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_EX1: begin
                case (op)
                    OP_MV: begin
                        sel     = imm ? SEL_IMM : {1'b0, ry};
                        RX_in   = rx_dec;
                        done    = 1'b1;
                        state_d = retire_state;
                    end
                    OP_MVT: begin
                        sel     = SEL_IMM;
                        RX_in   = rx_dec;
                        done    = 1'b1;
                        state_d = retire_state;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel     = {1'b0, rx};
                        A_in    = 1'b1;
                        state_d = ST_EX2;
                    end
                    OP_LD, OP_ST: begin
                        sel     = {1'b0, ry};
                        ADDR_in = 1'b1;
                        state_d = ST_EX2;
                    end
                    default: begin  // OP_B
                        if (br_taken) begin
                            sel     = SEL_PC;
                            A_in    = 1'b1;
                            state_d = ST_EX2;
                        end else begin
                            done    = 1'b1;
                            state_d = retire_state;
                        end
                    end
                endcase
            end

            ST_EX2: begin
                case (op)
                    OP_LD, OP_ST: begin
                        if (timeout) begin
                            err     = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            mem_req = 1'b1;
                            if (op == OP_ST) begin
                                sel     = {1'b0, rx};
                                DOUT_in = 1'b1;
                                W_D     = 1'b1;
                            end
                            if (mem_ready) begin
                                if (op == OP_LD) begin
                                    sel   = SEL_DIN;
                                    RX_in = rx_dec;
                                end
                                done    = 1'b1;
                                state_d = retire_state;
                            end else begin
                                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    OP_B: begin
                        sel     = SEL_IMM;
                        alu_op  = ALU_ADD;
                        G_in    = 1'b1;
                        state_d = ST_EX3;
                    end
                    default: begin  // ALU ops; MV/MVT never reach EX2
                        sel     = imm ? SEL_IMM : {1'b0, ry};
                        alu_op  = alu_for_op(op);
                        G_in    = 1'b1;
                        state_d = ST_EX3;
                    end
                endcase
            end

            ST_EX3: begin
                sel     = SEL_G;
                RX_in   = (op == OP_B) ? pc_dec : rx_dec;
                done    = 1'b1;
                state_d = retire_state;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_control_unit_seq.sv
// tb_control_unit_seq
//   Directed self-checking bench for control_unit_seq (NUM_REGS=8, MEM_WAIT_MAX=4).
//   Inputs change and outputs are sampled around the falling clock edge.
module tb_control_unit_seq;

    logic        clk = 1'b0;
    logic        reset, run, mem_ready, flag_z, flag_n, flag_c;
    logic [15:0] IR_out;
    logic [3:0]  sel;
    logic [1:0]  alu_op;
    logic        IR_in, A_in, G_in, ADDR_in, DOUT_in;
    logic [7:0]  RX_in;
    logic        pc_incr, mem_req, W_D, done, err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    control_unit_seq #(
        .DATA_W       (16),
        .NUM_REGS     (8),
        .MEM_WAIT_MAX (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .IR_out    (IR_out),
        .mem_ready (mem_ready),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .sel       (sel),
        .alu_op    (alu_op),
        .IR_in     (IR_in),
        .A_in      (A_in),
        .G_in      (G_in),
        .ADDR_in   (ADDR_in),
        .DOUT_in   (DOUT_in),
        .RX_in     (RX_in),
        .pc_incr   (pc_incr),
        .mem_req   (mem_req),
        .W_D       (W_D),
        .done      (done),
        .err       (err)
    );

    // Output snapshot: {sel, alu_op, en[IR,A,G,ADDR,DOUT], RX_in, ctl[pc_incr,mem_req,W_D,done,err]}
    logic [23:0] obs;
    assign obs = {sel, alu_op, IR_in, A_in, G_in, ADDR_in, DOUT_in, RX_in,
                  pc_incr, mem_req, W_D, done, err};

    localparam logic [4:0] E_IR = 5'b10000, E_A = 5'b01000, E_G = 5'b00100;
    localparam logic [4:0] E_AD = 5'b00010, E_DO = 5'b00001;
    localparam logic [4:0] C_PC = 5'b10000, C_MR = 5'b01000, C_WD = 5'b00100;
    localparam logic [4:0] C_DN = 5'b00010, C_ER = 5'b00001;

    function automatic logic [23:0] mk(input logic [3:0] s, input logic [1:0] a,
                                       input logic [4:0] en, input logic [7:0] rx,
                                       input logic [4:0] ct);
        return {s, a, en, rx, ct};
    endfunction

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply mem_ready, check outputs, advance to the next falling edge.
    task automatic cyc(input string tag, input logic rdy, input logic [23:0] exp);
        mem_ready = rdy;
        #1;
        check(tag, obs, exp);
        @(negedge clk);
    endtask

    task automatic fetch(input string tag, input logic [15:0] ir);
        IR_out = ir;
        cyc({tag, ".F0"}, 1'b0, mk(4'd7, 2'd0, E_AD, 8'h00, C_PC));
        cyc({tag, ".F1"}, 1'b1, mk(4'd0, 2'd0, E_IR, 8'h00, C_MR));
    endtask

    task automatic alu_instr(input string tag, input logic [15:0] ir, input logic [3:0] s1,
                             input logic [3:0] s2, input logic [1:0] a, input logic [7:0] rx);
        fetch(tag, ir);
        cyc({tag, ".EX1"}, 1'b1, mk(s1, 2'd0, E_A, 8'h00, 5'b0));  // ready ignored here
        cyc({tag, ".EX2"}, 1'b0, mk(s2, a, E_G, 8'h00, 5'b0));
        cyc({tag, ".EX3"}, 1'b0, mk(4'd9, 2'd0, 5'b0, rx, C_DN));
    endtask

    task automatic do_branch(input string tag, input logic [15:0] ir, input logic z,
                             input logic n, input logic c, input logic cond_taken);
        logic tk;
`ifdef CU_COND_BRANCH_EN
        tk = cond_taken;
`else
        tk = 1'b1;
`endif
        flag_z = z;
        flag_n = n;
        flag_c = c;
        fetch(tag, ir);
        if (tk) begin
            cyc({tag, ".EX1"}, 1'b0, mk(4'd7, 2'd0, E_A, 8'h00, 5'b0));
            cyc({tag, ".EX2"}, 1'b0, mk(4'd8, 2'd0, E_G, 8'h00, 5'b0));
            cyc({tag, ".EX3"}, 1'b0, mk(4'd9, 2'd0, 5'b0, 8'h80, C_DN));
        end else begin
            cyc({tag, ".EX1"}, 1'b0, mk(4'd0, 2'd0, 5'b0, 8'h00, C_DN));
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; mem_ready = 1'b0; IR_out = 16'h0;
        flag_z = 1'b0; flag_n = 1'b0; flag_c = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with run high: everything stays idle.
        cyc("rst0", 1'b0, 24'h0);
        cyc("rst1", 1'b0, 24'h0);
        reset = 1'b0;
        cyc("idle_after_rst", 1'b1, 24'h0);

        // MV R2,#5
        fetch("mv", 16'h1405);
        cyc("mv.EX1", 1'b0, mk(4'd8, 2'd0, 5'b0, 8'h04, C_DN));

        // MV R6,R3 (register source), F1 waits one cycle first
        IR_out = 16'h0C03;
        cyc("mvr.F0", 1'b1, mk(4'd7, 2'd0, E_AD, 8'h00, C_PC));  // ready ignored in F0
        cyc("mvr.F1w", 1'b0, mk(4'd0, 2'd0, 5'b0, 8'h00, C_MR));
        cyc("mvr.F1", 1'b1, mk(4'd0, 2'd0, E_IR, 8'h00, C_MR));
        cyc("mvr.EX1", 1'b0, mk(4'd3, 2'd0, 5'b0, 8'h40, C_DN));

        // ALU ops
        alu_instr("add", 16'h4203, 4'd1, 4'd3, 2'b00, 8'h02);
        alu_instr("sub", 16'h7A00, 4'd5, 4'd8, 2'b01, 8'h20);
        alu_instr("and", 16'hC006, 4'd0, 4'd6, 2'b10, 8'h01);

        // LD R4,[R0] with ready delayed 3 cycles
        fetch("ld", 16'h8800);
        cyc("ld.EX1", 1'b0, mk(4'd0, 2'd0, E_AD, 8'h00, 5'b0));
        for (int i = 0; i < 3; i++) cyc("ld.wait", 1'b0, mk(4'd0, 2'd0, 5'b0, 8'h00, C_MR));
        cyc("ld.rdy", 1'b1, mk(4'd10, 2'd0, 5'b0, 8'h10, C_MR | C_DN));

        // ST R3,[R1] with one wait cycle
        fetch("st", 16'hA601);
        cyc("st.EX1", 1'b0, mk(4'd1, 2'd0, E_AD, 8'h00, 5'b0));
        cyc("st.wait", 1'b0, mk(4'd3, 2'd0, E_DO, 8'h00, C_MR | C_WD));
        cyc("st.rdy", 1'b1, mk(4'd3, 2'd0, E_DO, 8'h00, C_MR | C_WD | C_DN));

        // Branches: ne with z=1 / z=0, eq with z=1, mi with n=0, cs with c=1
        do_branch("b_ne_z1", 16'hE400, 1'b1, 1'b0, 1'b0, 1'b0);
        do_branch("b_ne_z0", 16'hE400, 1'b0, 1'b0, 1'b0, 1'b1);
        do_branch("b_eq_z1", 16'hE200, 1'b1, 1'b0, 1'b0, 1'b1);
        do_branch("b_mi_n0", 16'hEC00, 1'b0, 1'b0, 1'b1, 1'b0);
        do_branch("b_cs_c1", 16'hE800, 1'b0, 1'b1, 1'b1, 1'b1);

        // LD timeout: 4 waits then err, no writeback, back to IDLE
        fetch("ldto", 16'h8800);
        cyc("ldto.EX1", 1'b0, mk(4'd0, 2'd0, E_AD, 8'h00, 5'b0));
        for (int i = 0; i < 4; i++) cyc("ldto.wait", 1'b0, mk(4'd0, 2'd0, 5'b0, 8'h00, C_MR));
        cyc("ldto.err", 1'b0, mk(4'd0, 2'd0, 5'b0, 8'h00, C_ER));
        cyc("ldto.idle", 1'b0, 24'h0);

        // Fetch timeout; the counter restarts per request
        cyc("fto.F0", 1'b0, mk(4'd7, 2'd0, E_AD, 8'h00, C_PC));
        for (int i = 0; i < 4; i++) cyc("fto.wait", 1'b0, mk(4'd0, 2'd0, 5'b0, 8'h00, C_MR));
        cyc("fto.err", 1'b1, mk(4'd0, 2'd0, 5'b0, 8'h00, C_ER));
        cyc("fto.idle", 1'b0, 24'h0);

        // Run drop mid-instruction: ADD completes, then stays IDLE
        fetch("rd", 16'h4203);
        cyc("rd.EX1", 1'b0, mk(4'd1, 2'd0, E_A, 8'h00, 5'b0));
        run = 1'b0;
        cyc("rd.EX2", 1'b0, mk(4'd3, 2'd0, E_G, 8'h00, 5'b0));
        cyc("rd.EX3", 1'b0, mk(4'd9, 2'd0, 5'b0, 8'h02, C_DN));
        cyc("rd.idle0", 1'b0, 24'h0);
        cyc("rd.idle1", 1'b1, 24'h0);
        run = 1'b1;
        cyc("rd.idle2", 1'b0, 24'h0);

        // Reset in the middle of an instruction aborts it
        fetch("rst_mid", 16'h4203);
        reset = 1'b1;
        cyc("rst_mid.EX1", 1'b0, mk(4'd1, 2'd0, E_A, 8'h00, 5'b0));
        reset = 1'b0;
        cyc("rst_mid.idle", 1'b0, 24'h0);
        cyc("rst_mid.F0", 1'b0, mk(4'd7, 2'd0, E_AD, 8'h00, C_PC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
